// File: rtl/addr_fifo_pkg.sv
// Shared constants and types for the 16-bit address FIFO.
// Contents:
//   DATA_W, DEPTH     word width and storage depth (DEPTH is a power of two, >= 4)
//   PTR_W, ADDR_W     pointer width with wrap bit, and RAM address width
//   RST_BUSY_CYC      posedges the reset-busy flags persist after rst_n release
//   ptr_t, addr_t, data_t, ptr_full()
package addr_fifo_pkg;

   localparam int unsigned DATA_W       = 16;
   localparam int unsigned DEPTH        = 16;
   localparam int unsigned PTR_W        = $clog2(DEPTH) + 1;
   localparam int unsigned ADDR_W       = PTR_W - 1;
   localparam int unsigned RST_BUSY_CYC = 2;
   localparam int unsigned BUSY_CNT_W   = $clog2(RST_BUSY_CYC + 1);

   typedef logic [PTR_W-1:0]  ptr_t;
   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;

   // Full when the pointers address the same slot but sit on different laps.
   function automatic logic ptr_full(ptr_t wr_ptr, ptr_t rd_ptr);
      return (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
             (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
   endfunction

endpackage

// File: rtl/addr_fifo_16b_if.sv
// Handshake/data bundle between an address producer/consumer and addr_fifo_16b.
// Optional build macro: FIFO_DATA_COUNT_EN adds the data_count signal.
// Modports:
//   master  drives din, wr_en, rd_en; observes dout, flags, busy (and data_count)
//   slave   the FIFO side of the same signals
interface addr_fifo_16b_if;
   import addr_fifo_pkg::*;

   data_t din;
   logic  wr_en;
   logic  rd_en;
   data_t dout;
   logic  full;
   logic  empty;
   logic  wr_rst_busy;
   logic  rd_rst_busy;
`ifdef FIFO_DATA_COUNT_EN
   ptr_t  data_count;

   modport master (
      output din, wr_en, rd_en,
      input  dout, full, empty, wr_rst_busy, rd_rst_busy, data_count
   );
   modport slave (
      input  din, wr_en, rd_en,
      output dout, full, empty, wr_rst_busy, rd_rst_busy, data_count
   );
`else
   modport master (
      output din, wr_en, rd_en,
      input  dout, full, empty, wr_rst_busy, rd_rst_busy
   );
   modport slave (
      input  din, wr_en, rd_en,
      output dout, full, empty, wr_rst_busy, rd_rst_busy
   );
`endif

endinterface

// File: rtl/addr_fifo_ram.sv
// DEPTH x DATA_W simple dual-port RAM: synchronous write, registered read with enable.
// Ports:
//   clk, rst_n     clock; async active-low reset clears only the read register
//   we/waddr/wdata write port
//   re/raddr       read port; rdata updates on the posedge where re is high
//   rdata          registered read data, holds when re is low
module addr_fifo_ram
   import addr_fifo_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  we,
   input  addr_t waddr,
   input  data_t wdata,
   input  logic  re,
   input  addr_t raddr,
   output data_t rdata
);

   data_t mem [DEPTH];
   data_t rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (re) begin
         rdata_q <= mem[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/addr_fifo_16b.sv
// Single-clock, standard-read (non-FWFT) FIFO for 16-bit CNN addresses.
// Optional build macro: FIFO_DATA_COUNT_EN enables the registered data_count output.
// Ports:
//   clk    single clock, all state on posedge
//   rst_n  asynchronous active-low reset
//   bus    addr_fifo_16b_if.slave: din/wr_en/rd_en in; dout/full/empty/busy flags out
module addr_fifo_16b
   import addr_fifo_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   addr_fifo_16b_if.slave    bus
);

   ptr_t wr_ptr_q, wr_ptr_d;
   ptr_t rd_ptr_q, rd_ptr_d;
   logic full_q, full_d;
   logic empty_q, empty_d;
   logic wr_ok, rd_ok;
   logic busy;

   logic [BUSY_CNT_W-1:0] busy_cnt_q, busy_cnt_d;

   // Busy counter is preloaded in reset and counts down after release.
   assign busy = (busy_cnt_q != '0);

   always_comb begin
      busy_cnt_d = busy_cnt_q;
      if (busy) begin
         busy_cnt_d = busy_cnt_q - BUSY_CNT_W'(1);
      end
   end

   always_comb begin
      wr_ok    = bus.wr_en & ~full_q & ~busy;
      rd_ok    = bus.rd_en & ~empty_q & ~busy;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_ok) begin
         wr_ptr_d = wr_ptr_q + ptr_t'(1);
      end
      if (rd_ok) begin
         rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end
      // Flags follow the next-state pointers so they change on the same edge as the op.
      full_d  = ptr_full(wr_ptr_d, rd_ptr_d);
      empty_d = (wr_ptr_d == rd_ptr_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         busy_cnt_q <= BUSY_CNT_W'(RST_BUSY_CYC);
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   // Read and write never hit the same slot in one cycle: a read needs a stored
   // word and a write needs a free one, so the addresses always differ.
   addr_fifo_ram u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_ok),
      .waddr (wr_ptr_q[ADDR_W-1:0]),
      .wdata (bus.din),
      .re    (rd_ok),
      .raddr (rd_ptr_q[ADDR_W-1:0]),
      .rdata (bus.dout)
   );

`ifdef FIFO_DATA_COUNT_EN
   ptr_t count_q, count_d;

   always_comb begin
      count_d = count_q;
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + ptr_t'(1);
         2'b01:   count_d = count_q - ptr_t'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign bus.data_count = count_q;
`endif

   assign bus.full        = full_q;
   assign bus.empty       = empty_q;
   assign bus.wr_rst_busy = busy;
   assign bus.rd_rst_busy = busy;

endmodule

// File: tb/tb_addr_fifo_16b.sv
// Directed self-checking bench for addr_fifo_16b.
// Optional build macro: FIFO_DATA_COUNT_EN adds data_count comparisons.
module tb_addr_fifo_16b;
   import addr_fifo_pkg::*;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_pass;

   addr_fifo_16b_if bus ();

   addr_fifo_16b dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1ns after each posedge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
   endtask

   task automatic write1(input data_t d);
      bus.din = d; bus.wr_en = 1'b1; bus.rd_en = 1'b0;
      tick();
      idle();
   endtask

   task automatic read1();
      bus.wr_en = 1'b0; bus.rd_en = 1'b1;
      tick();
      idle();
   endtask

   task automatic test_reset();
      bus.din = '0;
      idle();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #100;
      n_chk++; if (bus.empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", bus.empty); else n_pass++;
      n_chk++; if (bus.full !== 1'b0) $display("FAIL reset_full: got %b want 0", bus.full); else n_pass++;
      n_chk++; if (bus.dout !== 16'h0000) $display("FAIL reset_dout: got %h want 0000", bus.dout); else n_pass++;
      n_chk++; if ({bus.wr_rst_busy, bus.rd_rst_busy} !== 2'b11)
         $display("FAIL reset_busy: got %b want 11", {bus.wr_rst_busy, bus.rd_rst_busy}); else n_pass++;
`ifdef FIFO_DATA_COUNT_EN
      n_chk++; if (bus.data_count !== 5'd0) $display("FAIL reset_count: got %0d want 0", bus.data_count); else n_pass++;
`endif
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      n_chk++; if ({bus.wr_rst_busy, bus.rd_rst_busy} !== 2'b11)
         $display("FAIL busy_after_1: got %b want 11", {bus.wr_rst_busy, bus.rd_rst_busy}); else n_pass++;
      tick();
      n_chk++; if ({bus.wr_rst_busy, bus.rd_rst_busy} !== 2'b00)
         $display("FAIL busy_after_2: got %b want 00", {bus.wr_rst_busy, bus.rd_rst_busy}); else n_pass++;
   endtask

   // Writes 6,8,10,... for 10 cycles; reads run from cycle 5 until drained.
   task automatic test_stream();
      for (int i = 0; i < 15; i++) begin
         bus.wr_en = (i < 10);
         bus.din   = 16'(6 + 2 * i);
         bus.rd_en = (i >= 5);
         tick();
         if (i >= 5) begin
            n_chk++;
            if (bus.dout !== 16'(6 + 2 * (i - 5)))
               $display("FAIL stream_dout[%0d]: got %h want %h", i - 5, bus.dout, 16'(6 + 2 * (i - 5)));
            else n_pass++;
         end
      end
      idle();
      n_chk++; if (bus.empty !== 1'b1) $display("FAIL stream_empty: got %b want 1", bus.empty); else n_pass++;
   endtask

   task automatic test_fill();
      for (int i = 0; i < 16; i++) begin
         write1(16'h1000 + 16'(i));
         if (i == 14) begin
            n_chk++; if (bus.full !== 1'b0) $display("FAIL fill_full15: got %b want 0", bus.full); else n_pass++;
         end
         if (i == 0) begin
            n_chk++; if (bus.empty !== 1'b0) $display("FAIL fill_empty1: got %b want 0", bus.empty); else n_pass++;
         end
      end
      n_chk++; if (bus.full !== 1'b1) $display("FAIL fill_full16: got %b want 1", bus.full); else n_pass++;
      write1(16'hFFFF);
      n_chk++; if (bus.full !== 1'b1) $display("FAIL fill_full17: got %b want 1", bus.full); else n_pass++;
`ifdef FIFO_DATA_COUNT_EN
      n_chk++; if (bus.data_count !== 5'd16) $display("FAIL fill_count: got %0d want 16", bus.data_count); else n_pass++;
`endif
      for (int i = 0; i < 16; i++) begin
         read1();
         n_chk++;
         if (bus.dout !== 16'h1000 + 16'(i))
            $display("FAIL fill_dout[%0d]: got %h want %h", i, bus.dout, 16'h1000 + 16'(i));
         else n_pass++;
      end
      n_chk++; if ({bus.full, bus.empty} !== 2'b01)
         $display("FAIL fill_drained_flags: got %b want 01", {bus.full, bus.empty}); else n_pass++;
   endtask

   task automatic test_underflow();
      read1();
      n_chk++; if (bus.dout !== 16'h100F) $display("FAIL underflow_dout: got %h want 100f", bus.dout); else n_pass++;
      n_chk++; if (bus.empty !== 1'b1) $display("FAIL underflow_empty: got %b want 1", bus.empty); else n_pass++;
      write1(16'h5A5A);
      read1();
      n_chk++; if (bus.dout !== 16'h5A5A) $display("FAIL underflow_ptr: got %h want 5a5a", bus.dout); else n_pass++;
      n_chk++; if (bus.empty !== 1'b1) $display("FAIL underflow_empty2: got %b want 1", bus.empty); else n_pass++;
   endtask

   task automatic test_concurrency();
      data_t exp;
      // Count 0: write accepted, read dropped.
      bus.din = 16'hA0A0; bus.wr_en = 1'b1; bus.rd_en = 1'b1;
      tick();
      idle();
      n_chk++; if ({bus.full, bus.empty} !== 2'b00)
         $display("FAIL conc0_flags: got %b want 00", {bus.full, bus.empty}); else n_pass++;
      n_chk++; if (bus.dout !== 16'h5A5A) $display("FAIL conc0_dout: got %h want 5a5a", bus.dout); else n_pass++;
`ifdef FIFO_DATA_COUNT_EN
      n_chk++; if (bus.data_count !== 5'd1) $display("FAIL conc0_count: got %0d want 1", bus.data_count); else n_pass++;
`endif
      read1();
      n_chk++; if (bus.dout !== 16'hA0A0) $display("FAIL conc0_readback: got %h want a0a0", bus.dout); else n_pass++;

      // Count 8: both accepted, count unchanged.
      for (int i = 0; i < 8; i++) write1(16'h0200 + 16'(i));
      bus.din = 16'h02FF; bus.wr_en = 1'b1; bus.rd_en = 1'b1;
      tick();
      idle();
      n_chk++; if (bus.dout !== 16'h0200) $display("FAIL conc8_dout: got %h want 0200", bus.dout); else n_pass++;
      n_chk++; if ({bus.full, bus.empty} !== 2'b00)
         $display("FAIL conc8_flags: got %b want 00", {bus.full, bus.empty}); else n_pass++;
`ifdef FIFO_DATA_COUNT_EN
      n_chk++; if (bus.data_count !== 5'd8) $display("FAIL conc8_count: got %0d want 8", bus.data_count); else n_pass++;
`endif

      // Count 16: read accepted, write dropped.
      for (int i = 0; i < 8; i++) write1(16'h0300 + 16'(i));
      n_chk++; if (bus.full !== 1'b1) $display("FAIL conc16_pre_full: got %b want 1", bus.full); else n_pass++;
      bus.din = 16'hBEEF; bus.wr_en = 1'b1; bus.rd_en = 1'b1;
      tick();
      idle();
      n_chk++; if (bus.dout !== 16'h0201) $display("FAIL conc16_dout: got %h want 0201", bus.dout); else n_pass++;
      n_chk++; if (bus.full !== 1'b0) $display("FAIL conc16_full: got %b want 0", bus.full); else n_pass++;
`ifdef FIFO_DATA_COUNT_EN
      n_chk++; if (bus.data_count !== 5'd15) $display("FAIL conc16_count: got %0d want 15", bus.data_count); else n_pass++;
`endif
      for (int j = 0; j < 15; j++) begin
         if (j < 6)       exp = 16'h0202 + 16'(j);
         else if (j == 6) exp = 16'h02FF;
         else             exp = 16'h0300 + 16'(j - 7);
         read1();
         n_chk++;
         if (bus.dout !== exp) $display("FAIL conc_drain[%0d]: got %h want %h", j, bus.dout, exp);
         else n_pass++;
      end
      n_chk++; if (bus.empty !== 1'b1) $display("FAIL conc_drain_empty: got %b want 1", bus.empty); else n_pass++;
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 6; i++) write1(16'h0700 + 16'(i));
      read1();
      n_chk++; if (bus.dout !== 16'h0700) $display("FAIL areset_pre_dout: got %h want 0700", bus.dout); else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_chk++; if (bus.empty !== 1'b1) $display("FAIL areset_empty: got %b want 1", bus.empty); else n_pass++;
      n_chk++; if (bus.dout !== 16'h0000) $display("FAIL areset_dout: got %h want 0000", bus.dout); else n_pass++;
      n_chk++; if ({bus.full, bus.wr_rst_busy, bus.rd_rst_busy} !== 3'b011)
         $display("FAIL areset_flags: got %b want 011", {bus.full, bus.wr_rst_busy, bus.rd_rst_busy}); else n_pass++;
      #20;
      @(posedge clk);
      #1 rst_n = 1'b1;
      bus.din = 16'h1234; bus.wr_en = 1'b1;
      tick();
      tick();
      idle();
      n_chk++; if (bus.empty !== 1'b1) $display("FAIL areset_busy_write: got %b want 1", bus.empty); else n_pass++;
      n_chk++; if (bus.wr_rst_busy !== 1'b0) $display("FAIL areset_busy_clear: got %b want 0", bus.wr_rst_busy); else n_pass++;
      write1(16'h4321);
      read1();
      n_chk++; if (bus.dout !== 16'h4321) $display("FAIL areset_recover: got %h want 4321", bus.dout); else n_pass++;
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      test_reset();
      test_stream();
      test_fill();
      test_underflow();
      test_concurrency();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
